uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Round-robin byte scheduler for four requesters feeding one
//               UART transmitter. Define UART_TX_SCHED_TAG_EN to prefix each
//               data byte with a tag byte {4'hA, 2'b00, id}.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 16,
  parameter int BUSY_TMO   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [8*NREQ-1:0] i_data,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy,
  output logic              o_busy,
  output logic [1:0]        o_last_id
);

  localparam logic [7:0] c_tmo_last = 8'(BUSY_TMO - 1);
  localparam logic [7:0] c_gap_last = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
`ifdef UART_TX_SCHED_TAG_EN
    ,
    LOAD_DATA = 3'd5
`endif
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  state_t     w_after_byte;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_win;
  logic [7:0] w_win_byte;
  logic [7:0] r_tx_data;
  logic [1:0] r_last_id;
  logic       w_take;
`ifdef UART_TX_SCHED_TAG_EN
  logic [7:0] r_byte;
  logic       r_tag_phase;
`endif

  // Scan from the highest offset down so the nearest requester after r_ptr wins.
  always_comb begin
    w_win = r_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[r_ptr + 2'(i)]) begin
        w_win = r_ptr + 2'(i);
      end
    end
  end

  assign w_win_byte = i_data[{w_win, 3'b000} +: 8];
  assign w_take     = (r_state == IDLE) && (|i_req);

`ifdef UART_TX_SCHED_TAG_EN
  assign w_after_byte = r_tag_phase ? LOAD_DATA : GAP;
`else
  assign w_after_byte = GAP;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (|i_req) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_state_nxt = WAIT_BUSY;
        w_cnt_nxt   = '0;
      end
      WAIT_BUSY: begin
        // A late busy rise on the final timeout cycle still counts as a frame.
        if (i_tx_busy) begin
          w_state_nxt = WAIT_DONE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_tmo_last) begin
          w_state_nxt = w_after_byte;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          w_state_nxt = w_after_byte;
          w_cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (r_cnt == c_gap_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
`ifdef UART_TX_SCHED_TAG_EN
      LOAD_DATA: begin
        w_state_nxt = WAIT_BUSY;
        w_cnt_nxt   = '0;
      end
`endif
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_last_id   <= '0;
      r_tx_data   <= '0;
`ifdef UART_TX_SCHED_TAG_EN
      r_byte      <= '0;
      r_tag_phase <= 1'b0;
`endif
    end else begin
      if (w_take) begin
        r_ptr       <= w_win + 2'd1;
        r_last_id   <= w_win;
`ifdef UART_TX_SCHED_TAG_EN
        r_tx_data   <= {4'hA, 2'b00, w_win};
        r_byte      <= w_win_byte;
        r_tag_phase <= 1'b1;
`else
        r_tx_data   <= w_win_byte;
`endif
      end
`ifdef UART_TX_SCHED_TAG_EN
      if (w_state_nxt == LOAD_DATA) begin
        r_tx_data   <= r_byte;
        r_tag_phase <= 1'b0;
      end
`endif
    end
  end

  assign o_grant   = (r_state == LOAD) ? (NREQ'(1) << r_last_id) : '0;
  assign o_tx_data = r_tx_data;
  assign o_busy    = (r_state != IDLE);
  assign o_last_id = r_last_id;

`ifdef UART_TX_SCHED_TAG_EN
  assign o_tx_start = (r_state == LOAD) || (r_state == LOAD_DATA);
`else
  assign o_tx_start = (r_state == LOAD);
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Randomized self-checking bench for uart_tx_sched with a
//               behavioural transmitter and round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  localparam int GAP = 16;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  i_req = '0;
  logic [31:0] i_data = '0;
  logic        i_tx_busy = 1'b0;
  logic [3:0]  o_grant;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic [1:0]  o_last_id;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int nstart = 0;
  int tx_from = -1;
  int tx_to = -1;
  int tx_d = 3;
  int tx_l = 4;
  bit tx_on = 1'b1;
  int m_ptr = 0;
  logic [7:0] data_b [4];

  uart_tx_sched #(
    .NREQ       (4),
    .GAP_CYCLES (GAP),
    .BUSY_TMO   (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_grant    (o_grant),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_busy  (i_tx_busy),
    .o_busy     (o_busy),
    .o_last_id  (o_last_id)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic drive_data();
    i_data = {data_b[3], data_b[2], data_b[1], data_b[0]};
  endtask

  // Advance one clock; the transmitter model raises busy tx_d cycles after a start for tx_l cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (o_tx_start) begin
      nstart++;
      tx_from = cyc + tx_d;
      tx_to   = cyc + tx_d + tx_l - 1;
    end
    i_tx_busy = tx_on && (cyc >= tx_from) && (cyc <= tx_to);
    check_eq("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
  endtask

  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    i_req = '0;
    tx_from = -1;
    tx_to = -1;
    i_tx_busy = 1'b0;
    repeat (2) tick();
    check_eq("rst_grant", o_grant, 0);
    check_eq("rst_start", o_tx_start, 0);
    check_eq("rst_tx_data", o_tx_data, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_last_id", o_last_id, 0);
    reset = 1'b0;
  endtask

  // Follow one grant end to end: grant cycle, every byte start, gap length, return to idle.
  task automatic do_frame(input int exp_id, input bit drop, input int lat_ref);
    int n, s, p, n0, nb;
    logic [7:0] exp_b [2];
    logic [3:0] g;
    n = 0;
    while (o_grant == '0 && n < 300) begin
      tick();
      n++;
    end
    check_eq("grant_id", o_grant, 32'(4'b0001 << exp_id));
    if (o_grant == '0) return;
    if (lat_ref >= 0) check_eq("grant_latency", cyc - lat_ref, 1);
    check_eq("last_id", o_last_id, exp_id);
    check_eq("busy_in_load", o_busy, 1);
`ifdef UART_TX_SCHED_TAG_EN
    nb = 2;
    exp_b[0] = {4'hA, 2'b00, 2'(exp_id)};
    exp_b[1] = data_b[exp_id];
`else
    nb = 1;
    exp_b[0] = data_b[exp_id];
    exp_b[1] = data_b[exp_id];
`endif
    n0 = nstart - 1;
    if (drop) begin
      i_req[exp_id] = 1'b0;
      data_b[exp_id] = 8'($urandom);
      drive_data();
    end
    p = tx_on ? (tx_d + tx_l + 1) : (TMO + 1);
    s = cyc;
    for (int b = 0; b < nb; b++) begin
      if (b > 0) begin
        while (cyc < s + p) tick();
        s = cyc;
        check_eq("no_regrant", o_grant, 0);
      end
      check_eq("start", o_tx_start, 1);
      check_eq("tx_data", o_tx_data, exp_b[b]);
    end
    while (cyc < s + p) tick();
    g = 4'($urandom) & ~i_req;
    i_req = i_req | g;
    tick();
    i_req = i_req & ~g;
    while (cyc < s + p + GAP - 1) tick();
    check_eq("busy_gap_end", o_busy, 1);
    check_eq("tx_data_held", o_tx_data, exp_b[nb-1]);
    tick();
    check_eq("idle_time", o_busy, 0);
    check_eq("start_count", nstart - n0, nb);
  endtask

  initial begin
    int n, n0, w;
    logic [3:0] add;
    for (int k = 0; k < 4; k++) data_b[k] = 8'($urandom);
    drive_data();
    apply_reset();

    // Single request on port 1
    tx_on = 1'b1; tx_d = 3; tx_l = 100;
    data_b[1] = 8'h55;
    drive_data();
    i_req = 4'b0010;
    do_frame(1, 1'b1, cyc);

    // Round robin from a fresh pointer, twice
    apply_reset();
    tx_d = 2; tx_l = 3;
    for (int r = 0; r < 2; r++) begin
      i_req = 4'b1111;
      for (int k = 0; k < 4; k++) do_frame(k, 1'b1, cyc);
    end

    // Fairness with two permanently held requests
    i_req = 4'b0101;
    for (int f = 0; f < 8; f++) do_frame((f % 2) * 2, 1'b0, cyc);
    i_req = '0;

    // Transmitter never responds
    tx_on = 1'b0;
    i_req = 4'b0001;
    do_frame(0, 1'b1, cyc);
    tx_on = 1'b1;

    // Reset in the middle of a frame
    tx_d = 2; tx_l = 40;
    data_b[2] = 8'h9E;
    drive_data();
    i_req = 4'b0100;
    n = 0;
    while (o_grant == '0 && n < 50) begin tick(); n++; end
    check_eq("rst_pre_grant", o_grant, 32'h4);
    i_req = '0;
    n = 0;
    while (!i_tx_busy && n < 50) begin tick(); n++; end
    tick();
    tick();
    check_eq("rst_pre_busy", o_busy, 1);
    n0 = nstart;
    #3;
    reset = 1'b1;
    #1;
    check_eq("rst_async_grant", o_grant, 0);
    check_eq("rst_async_start", o_tx_start, 0);
    check_eq("rst_async_data", o_tx_data, 0);
    check_eq("rst_async_busy", o_busy, 0);
    check_eq("rst_async_last", o_last_id, 0);
    tx_from = -1;
    tx_to = -1;
    i_tx_busy = 1'b0;
    data_b[1] = 8'($urandom);
    data_b[3] = 8'($urandom);
    drive_data();
    i_req = 4'b1010;
    tick();
    tick();
    check_eq("rst_no_start", nstart - n0, 0);
    reset = 1'b0;
    do_frame(1, 1'b1, cyc);
    do_frame(3, 1'b1, cyc);

    // Randomized traffic against the round-robin model
    m_ptr = 0;
    for (int i = 0; i < 40; i++) begin
      tx_d = (i == 0) ? 1 : (i == 1) ? TMO : int'($urandom_range(1, TMO));
      tx_l = int'($urandom_range(1, 12));
      tx_on = ($urandom_range(0, 99) < 85);
      add = 4'($urandom_range(0, 15)) & ~i_req;
      if ((i_req | add) == '0) add = 4'b0001 << $urandom_range(0, 3);
      for (int k = 0; k < 4; k++) begin
        if (add[k]) data_b[k] = 8'($urandom);
      end
      drive_data();
      i_req = i_req | add;
      w = rr_pick(i_req, m_ptr);
      m_ptr = (w + 1) % 4;
      do_frame(w, 1'b1, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
